// File: rtl/register_unloader.sv
// Parallel-in / serial-out unloader: captures a word on load, hands it out one bit
// per valid/ready transfer, then pulses done for one cycle before returning to idle.
module register_unloader #(
  parameter int LENGTH    = 5,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           load,
  input  logic [LENGTH-1:0]              D,
  input  logic                           ready,
  output logic                           serial_out,
  output logic                           valid,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(LENGTH+1)-1:0]    remaining
);

  localparam int CW = $clog2(LENGTH+1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        r_state;
  logic [LENGTH-1:0] r_shreg;
  logic [CW-1:0]     r_remaining;

  logic              w_in_shift;
  logic              w_xfer;
  logic              w_last;
  logic              w_head_bit;
  logic [LENGTH-1:0] w_shifted;

  assign w_in_shift = (r_state == SHIFT);
  assign w_xfer     = w_in_shift && ready;
  assign w_last     = (r_remaining == CW'(1));

  // Shift toward whichever end feeds serial_out, zero-filling behind.
  assign w_shifted  = MSB_FIRST ? {r_shreg[LENGTH-2:0], 1'b0}
                                : {1'b0, r_shreg[LENGTH-1:1]};
  assign w_head_bit = MSB_FIRST ? r_shreg[LENGTH-1] : r_shreg[0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load) begin
            r_shreg     <= D;
            r_remaining <= CW'(LENGTH);
            r_state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_xfer) begin
            r_shreg     <= w_shifted;
            r_remaining <= r_remaining - 1'b1;
            if (w_last) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
          r_shreg     <= '0;
          r_remaining <= '0;
        end
      endcase
    end
  end

  // Every output decodes registered state only; ready and load never reach them.
  assign valid      = w_in_shift;
  assign busy       = (r_state == SHIFT) || (r_state == DONE);
  assign done       = (r_state == DONE);
  assign serial_out = w_in_shift & w_head_bit;
  assign remaining  = r_remaining;

endmodule

// File: tb/tb_register_unloader.sv
// Directed bench for register_unloader: one MSB-first and one LSB-first instance share stimulus.
module tb_register_unloader;

  logic       clock;
  logic       reset;
  logic       load;
  logic [4:0] D;
  logic       ready;

  logic       m_serial_out, m_valid, m_busy, m_done;
  logic [2:0] m_remaining;
  logic       l_serial_out, l_valid, l_busy, l_done;
  logic [2:0] l_remaining;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  register_unloader #(.LENGTH(5), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .reset(reset), .load(load), .D(D), .ready(ready),
    .serial_out(m_serial_out), .valid(m_valid), .busy(m_busy),
    .done(m_done), .remaining(m_remaining)
  );

  register_unloader #(.LENGTH(5), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .reset(reset), .load(load), .D(D), .ready(ready),
    .serial_out(l_serial_out), .valid(l_valid), .busy(l_busy),
    .done(l_done), .remaining(l_remaining)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load  = 1'($urandom_range(0, 1));
      D     = 5'($urandom);
      ready = 1'($urandom_range(0, 1));
      tick();
      assert_cnt++;
      if ({m_valid, m_busy, m_done, m_serial_out, m_remaining} !== 7'b0) begin
        fail_cnt++;
        $display("FAIL reset_msb: got v=%b b=%b d=%b s=%b rem=%0d, need all 0",
                 m_valid, m_busy, m_done, m_serial_out, m_remaining);
      end
    end
    assert_cnt++;
    if ({l_valid, l_busy, l_done, l_serial_out, l_remaining} !== 7'b0) begin
      fail_cnt++;
      $display("FAIL reset_lsb: got v=%b b=%b d=%b s=%b rem=%0d, need all 0",
               l_valid, l_busy, l_done, l_serial_out, l_remaining);
    end
    load = 1'b0; ready = 1'b0; D = '0;
    reset = 1'b1;
    tick();
  endtask

  // Load coincides with ready=1 so load-wins-in-IDLE is exercised too.
  task automatic test_msb_stream();
    logic [4:0] w;
    w = 5'b10110;
    load = 1'b1; D = w; ready = 1'b1;
    tick();
    load = 1'b0; D = '0;
    for (int i = 0; i < 5; i++) begin
      assert_cnt++;
      if (m_valid !== 1'b1 || m_busy !== 1'b1 || m_serial_out !== w[4-i] ||
          m_remaining !== 3'(5-i)) begin
        fail_cnt++;
        $display("FAIL msb_bit%0d: got v=%b b=%b s=%b rem=%0d, need v=1 b=1 s=%b rem=%0d",
                 i, m_valid, m_busy, m_serial_out, m_remaining, w[4-i], 5-i);
      end
      tick();
    end
    assert_cnt++;
    if (m_done !== 1'b1 || m_valid !== 1'b0 || m_busy !== 1'b1 || m_remaining !== 3'd0) begin
      fail_cnt++;
      $display("FAIL msb_done: got d=%b v=%b b=%b rem=%0d, need d=1 v=0 b=1 rem=0",
               m_done, m_valid, m_busy, m_remaining);
    end
    tick();
    assert_cnt++;
    if (m_done !== 1'b0 || m_busy !== 1'b0 || m_valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL msb_idle: got d=%b b=%b v=%b, need all 0", m_done, m_busy, m_valid);
    end
    ready = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    logic [4:0] w;
    logic [3:0] pat;
    int k;
    logic was_xfer;
    w = 5'b10110;
    pat = 4'b1001;
    k = 0;
    load = 1'b1; D = w; ready = 1'b0;
    tick();
    load = 1'b0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      assert_cnt++;
      if (m_valid !== 1'b1 || m_serial_out !== w[4-k] || m_remaining !== 3'(5-k)) begin
        fail_cnt++;
        $display("FAIL stall_c%0d: got v=%b s=%b rem=%0d, need v=1 s=%b rem=%0d",
                 c, m_valid, m_serial_out, m_remaining, w[4-k], 5-k);
      end
      ready = pat[3 - (c % 4)];
      was_xfer = ready && m_valid;
      tick();
      if (was_xfer) k++;
    end
    assert_cnt++;
    if (k != 5 || m_done !== 1'b1) begin
      fail_cnt++;
      $display("FAIL stall_done: got transfers=%0d done=%b, need transfers=5 done=1", k, m_done);
    end
    ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0] w1, w2;
    w1 = 5'b10110;
    w2 = 5'b01001;
    load = 1'b1; D = w1; ready = 1'b1;
    tick();
    // Second word held on load through SHIFT and DONE; must only land from IDLE.
    D = w2;
    for (int i = 0; i < 5; i++) begin
      assert_cnt++;
      if (m_valid !== 1'b1 || m_serial_out !== w1[4-i]) begin
        fail_cnt++;
        $display("FAIL b2b_first%0d: got v=%b s=%b, need v=1 s=%b",
                 i, m_valid, m_serial_out, w1[4-i]);
      end
      tick();
    end
    assert_cnt++;
    if (m_done !== 1'b1 || m_valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL b2b_done: got d=%b v=%b, need d=1 v=0", m_done, m_valid);
    end
    tick();
    assert_cnt++;
    if (m_busy !== 1'b0 || m_valid !== 1'b0 || m_done !== 1'b0) begin
      fail_cnt++;
      $display("FAIL b2b_idle: got b=%b v=%b d=%b, need all 0", m_busy, m_valid, m_done);
    end
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      assert_cnt++;
      if (m_valid !== 1'b1 || m_serial_out !== w2[4-i] || m_remaining !== 3'(5-i)) begin
        fail_cnt++;
        $display("FAIL b2b_second%0d: got v=%b s=%b rem=%0d, need v=1 s=%b rem=%0d",
                 i, m_valid, m_serial_out, m_remaining, w2[4-i], 5-i);
      end
      tick();
    end
    assert_cnt++;
    if (m_done !== 1'b1) begin
      fail_cnt++;
      $display("FAIL b2b_done2: got d=%b, need 1", m_done);
    end
    ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [4:0] w;
    logic saw_done;
    w = 5'b11010;
    saw_done = 1'b0;
    load = 1'b1; D = w; ready = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    #3;
    reset = 1'b0;
    #1;
    assert_cnt++;
    if ({m_valid, m_busy, m_done, m_serial_out, m_remaining} !== 7'b0) begin
      fail_cnt++;
      $display("FAIL mid_reset_async: got v=%b b=%b d=%b s=%b rem=%0d, need all 0",
               m_valid, m_busy, m_done, m_serial_out, m_remaining);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (m_done === 1'b1 || m_valid === 1'b1) saw_done = 1'b1;
      tick();
    end
    assert_cnt++;
    if (saw_done !== 1'b0) begin
      fail_cnt++;
      $display("FAIL mid_reset_quiet: got activity=%b after abort, need 0", saw_done);
    end
    w = 5'b01101;
    load = 1'b1; D = w;
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      assert_cnt++;
      if (m_valid !== 1'b1 || m_serial_out !== w[4-i] || m_remaining !== 3'(5-i)) begin
        fail_cnt++;
        $display("FAIL post_reset%0d: got v=%b s=%b rem=%0d, need v=1 s=%b rem=%0d",
                 i, m_valid, m_serial_out, m_remaining, w[4-i], 5-i);
      end
      tick();
    end
    assert_cnt++;
    if (m_done !== 1'b1) begin
      fail_cnt++;
      $display("FAIL post_reset_done: got d=%b, need 1", m_done);
    end
    ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_lsb_first();
    logic [4:0] exp_bits;
    exp_bits = 5'b10110;
    load = 1'b1; D = 5'b10110; ready = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      assert_cnt++;
      if (l_valid !== 1'b1 || l_serial_out !== exp_bits[i] || l_remaining !== 3'(5-i)) begin
        fail_cnt++;
        $display("FAIL lsb_bit%0d: got v=%b s=%b rem=%0d, need v=1 s=%b rem=%0d",
                 i, l_valid, l_serial_out, l_remaining, exp_bits[i], 5-i);
      end
      tick();
    end
    assert_cnt++;
    if (l_done !== 1'b1 || l_remaining !== 3'd0 || l_valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL lsb_done: got d=%b rem=%0d v=%b, need d=1 rem=0 v=0",
               l_done, l_remaining, l_valid);
    end
    ready = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; D = '0; ready = 1'b0;
    #1;
    test_reset();
    test_msb_stream();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_lsb_first();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
